// File: rtl/wr_dio_pkg.sv
// Shared types, register-map offsets and bit positions for the wr_dio block.
package wr_dio_pkg;

    typedef enum logic {PIPELINED = 1'b0, CLASSIC = 1'b1} t_wb_mode;
    typedef enum logic {BYTE = 1'b0, WORD = 1'b1} t_wb_gran;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned TRIG_CYC_W = 28;
    localparam int unsigned CH_W       = 3;

    localparam logic [ADDR_W-1:0] REG_TRIG_SEC = 3'd0;
    localparam logic [ADDR_W-1:0] REG_TRIG_CYC = 3'd1;
    localparam logic [ADDR_W-1:0] REG_CTRL     = 3'd2;
    localparam logic [ADDR_W-1:0] REG_OUT      = 3'd3;
    localparam logic [ADDR_W-1:0] REG_OE       = 3'd4;
    localparam logic [ADDR_W-1:0] REG_IN       = 3'd5;
    localparam logic [ADDR_W-1:0] REG_STATUS   = 3'd6;

    localparam int unsigned CTRL_ARM    = 8;
    localparam int unsigned CTRL_DISARM = 9;
    localparam int unsigned STAT_ARMED  = 0;
    localparam int unsigned STAT_VALID  = 1;
    localparam int unsigned STAT_ACTIVE = 2;
`ifdef WR_DIO_IRQ_EN
    localparam int unsigned CTRL_IRQ_EN = 16;
    localparam int unsigned STAT_FIRED  = 3;
`endif

    // Byte-lane merge of a Wishbone write into an existing 32-bit value.
    function automatic logic [31:0] f_sel_merge(input logic [31:0] old_val,
                                                input logic [31:0] wr_val,
                                                input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_val & ~mask) | (wr_val & mask);
    endfunction

endpackage

// File: rtl/wr_dio_wb_slave.sv
// Wishbone handshake, address decode and register file for wr_dio.
// Optional interrupt logic is built when WR_DIO_IRQ_EN is defined.
module wr_dio_wb_slave
    import wr_dio_pkg::*;
#(
    parameter int unsigned g_num_channels        = 5,
    parameter t_wb_mode    g_interface_mode      = PIPELINED,
    parameter t_wb_gran    g_address_granularity = BYTE
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [3:0]                wb_sel_i,
    input  logic [31:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    input  logic [g_num_channels-1:0] i_in_sync,
    input  logic                      i_time_valid,
    input  logic                      i_match,
    input  logic                      i_pulse_active,
`ifdef WR_DIO_IRQ_EN
    output logic                      o_irq,
`endif
    output logic [31:0]               o_trig_sec,
    output logic [TRIG_CYC_W-1:0]     o_trig_cyc,
    output logic [CH_W-1:0]           o_ch,
    output logic                      o_armed,
    output logic [g_num_channels-1:0] o_out,
    output logic [g_num_channels-1:0] o_oe
);

    localparam int unsigned N = g_num_channels;

    logic                  r_ack;
    logic [31:0]           r_dat;
    logic [31:0]           r_trig_sec;
    logic [TRIG_CYC_W-1:0] r_trig_cyc;
    logic [CH_W-1:0]       r_ch;
    logic                  r_armed;
    logic [N-1:0]          r_out;
    logic [N-1:0]          r_oe;
`ifdef WR_DIO_IRQ_EN
    logic                  r_fired;
    logic                  r_irq_en;
    logic                  r_irq;
    logic                  w_fired_clr;
`endif

    logic              w_req;
    logic              w_wr;
    logic              w_arm_wr;
    logic              w_disarm_wr;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rdata;
    logic              w_unused;

    // In CLASSIC mode the request still visible during its ack cycle is the same access.
    assign w_req       = wb_cyc_i & wb_stb_i & ~((g_interface_mode == CLASSIC) & r_ack);
    assign w_idx       = (g_address_granularity == BYTE) ? wb_adr_i[4:2] : wb_adr_i[2:0];
    assign w_wr        = w_req & wb_we_i;
    assign w_arm_wr    = w_wr & (w_idx == REG_CTRL) & wb_sel_i[1] & wb_dat_i[CTRL_ARM];
    assign w_disarm_wr = w_wr & (w_idx == REG_CTRL) & wb_sel_i[1] & wb_dat_i[CTRL_DISARM];
    assign w_unused    = ^wb_adr_i;
`ifdef WR_DIO_IRQ_EN
    assign w_fired_clr = w_wr & (w_idx == REG_STATUS) & wb_sel_i[0] & wb_dat_i[STAT_FIRED];
`endif

    // Read mux; unimplemented bits read 0.
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_TRIG_SEC: w_rdata = r_trig_sec;
            REG_TRIG_CYC: w_rdata[TRIG_CYC_W-1:0] = r_trig_cyc;
            REG_CTRL: begin
                w_rdata[CH_W-1:0] = r_ch;
                w_rdata[CTRL_ARM] = r_armed;
`ifdef WR_DIO_IRQ_EN
                w_rdata[CTRL_IRQ_EN] = r_irq_en;
`endif
            end
            REG_OUT:    w_rdata[N-1:0] = r_out;
            REG_OE:     w_rdata[N-1:0] = r_oe;
            REG_IN:     w_rdata[N-1:0] = i_in_sync;
            REG_STATUS: begin
                w_rdata[STAT_ARMED]  = r_armed;
                w_rdata[STAT_VALID]  = i_time_valid;
                w_rdata[STAT_ACTIVE] = i_pulse_active;
`ifdef WR_DIO_IRQ_EN
                w_rdata[STAT_FIRED]  = r_fired;
`endif
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_trig_sec <= '0;
            r_trig_cyc <= '0;
            r_ch       <= '0;
            r_armed    <= 1'b0;
            r_out      <= '0;
            r_oe       <= '0;
`ifdef WR_DIO_IRQ_EN
            r_fired    <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
`endif
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rdata : '0;
            if (w_wr) begin
                case (w_idx)
                    REG_TRIG_SEC: r_trig_sec <= f_sel_merge(r_trig_sec, wb_dat_i, wb_sel_i);
                    REG_TRIG_CYC: r_trig_cyc <= TRIG_CYC_W'(f_sel_merge(32'(r_trig_cyc), wb_dat_i, wb_sel_i));
                    REG_CTRL: begin
                        if (wb_sel_i[0]) r_ch <= wb_dat_i[CH_W-1:0];
`ifdef WR_DIO_IRQ_EN
                        if (wb_sel_i[2]) r_irq_en <= wb_dat_i[CTRL_IRQ_EN];
`endif
                    end
                    REG_OUT: r_out <= N'(f_sel_merge(32'(r_out), wb_dat_i, wb_sel_i));
                    REG_OE:  r_oe  <= N'(f_sel_merge(32'(r_oe), wb_dat_i, wb_sel_i));
                    default: ;
                endcase
            end
            // DISARM beats ARM; a fresh ARM beats the match that consumed the old one.
            if (w_disarm_wr)   r_armed <= 1'b0;
            else if (w_arm_wr) r_armed <= 1'b1;
            else if (i_match)  r_armed <= 1'b0;
`ifdef WR_DIO_IRQ_EN
            if (i_match)          r_fired <= 1'b1;
            else if (w_fired_clr) r_fired <= 1'b0;
            r_irq <= r_fired & r_irq_en;
`endif
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign o_trig_sec = r_trig_sec;
    assign o_trig_cyc = r_trig_cyc;
    assign o_ch       = r_ch;
    assign o_armed    = r_armed;
    assign o_out      = r_out;
    assign o_oe       = r_oe;
`ifdef WR_DIO_IRQ_EN
    assign o_irq      = r_irq;
`endif

endmodule

// File: rtl/wr_dio.sv
// White Rabbit DIO block: input synchronizer, TAI trigger comparator and pulse generator.
// Define WR_DIO_IRQ_EN to add the sticky fired flag and irq_o output.
module wr_dio
    import wr_dio_pkg::*;
#(
    parameter int unsigned g_num_channels        = 5,
    parameter int unsigned g_pulse_len           = 10,
    parameter t_wb_mode    g_interface_mode      = PIPELINED,
    parameter t_wb_gran    g_address_granularity = BYTE
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_i,
    input  logic                      tm_time_valid_i,
    input  logic [31:0]               tm_seconds_i,
    input  logic [27:0]               tm_cycles_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [3:0]                wb_sel_i,
    input  logic [31:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_stall_o,
`ifdef WR_DIO_IRQ_EN
    output logic                      irq_o,
`endif
    input  logic [g_num_channels-1:0] dio_in_i,
    output logic [g_num_channels-1:0] dio_out_o,
    output logic [g_num_channels-1:0] dio_oe_o
);

    localparam int unsigned N     = g_num_channels;
    localparam int unsigned CNT_W = $clog2(g_pulse_len + 1);

    logic [N-1:0]          r_sync1;
    logic [N-1:0]          r_sync2;
    logic [N-1:0]          r_dio_out;
    logic [CNT_W-1:0]      r_cnt;
    logic [CH_W-1:0]       r_pulse_ch;

    logic [N-1:0]          w_out;
    logic [N-1:0]          w_oe;
    logic [N-1:0]          w_pulse_bits;
    logic [CH_W-1:0]       w_ch;
    logic [31:0]           w_trig_sec;
    logic [TRIG_CYC_W-1:0] w_trig_cyc;
    logic                  w_armed;
    logic                  w_match;
    logic                  w_fire;
    logic                  w_active;

    wr_dio_wb_slave #(
        .g_num_channels       (g_num_channels),
        .g_interface_mode     (g_interface_mode),
        .g_address_granularity(g_address_granularity)
    ) u_wb_slave (
        .clk_sys_i     (clk_sys_i),
        .rst_i         (rst_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_we_i       (wb_we_i),
        .wb_sel_i      (wb_sel_i),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .i_in_sync     (r_sync2),
        .i_time_valid  (tm_time_valid_i),
        .i_match       (w_match),
        .i_pulse_active(w_active),
`ifdef WR_DIO_IRQ_EN
        .o_irq         (irq_o),
`endif
        .o_trig_sec    (w_trig_sec),
        .o_trig_cyc    (w_trig_cyc),
        .o_ch          (w_ch),
        .o_armed       (w_armed),
        .o_out         (w_out),
        .o_oe          (w_oe)
    );

    // A match on an out-of-range channel still consumes the arm but fires nothing.
    assign w_match  = w_armed & tm_time_valid_i & (tm_seconds_i == w_trig_sec) &
                      (tm_cycles_i == w_trig_cyc);
    assign w_fire   = w_match & (32'(w_ch) < N);
    assign w_active = (r_cnt != '0);

    // r_cnt counts the pulse cycles still to show, including the current one.
    always_comb begin
        w_pulse_bits = '0;
        if (w_fire)                    w_pulse_bits = N'(1) << w_ch;
        else if (r_cnt > CNT_W'(1))    w_pulse_bits = N'(1) << r_pulse_ch;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_dio_out  <= '0;
            r_cnt      <= '0;
            r_pulse_ch <= '0;
        end else begin
            r_sync1   <= dio_in_i;
            r_sync2   <= r_sync1;
            r_dio_out <= w_out | w_pulse_bits;
            if (w_fire) begin
                r_cnt      <= CNT_W'(g_pulse_len);
                r_pulse_ch <= w_ch;
            end else if (w_active) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign dio_out_o  = r_dio_out;
    assign dio_oe_o   = w_oe;
    assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_wr_dio.sv
// Self-checking bench for wr_dio: directed steps plus randomized register and trigger traffic.
`timescale 1ns/1ps
module tb_wr_dio;
    import wr_dio_pkg::*;

    localparam int unsigned N = 5;
    localparam int unsigned L = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tm_valid = 1'b0;
    logic [31:0]   tm_sec = '0;
    logic [27:0]   tm_cyc = '0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   adr = '0, dat_i = '0;
    logic [31:0]   dat_o;
    logic          ack, stall;
    logic [N-1:0]  dio_in = '0;
    logic [N-1:0]  dio_out, dio_oe;
`ifdef WR_DIO_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0]   m_sec, m_cyc;
    logic [2:0]    m_ch;
    logic          m_armed;
    logic [N-1:0]  m_out, m_oe, m_in;

    always #5 clk = ~clk;

    wr_dio #(.g_num_channels(N), .g_pulse_len(L)) dut (
        .clk_sys_i(clk), .rst_i(rst),
        .tm_time_valid_i(tm_valid), .tm_seconds_i(tm_sec), .tm_cycles_i(tm_cyc),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_stall_o(stall),
`ifdef WR_DIO_IRQ_EN
        .irq_o(irq),
`endif
        .dio_in_i(dio_in), .dio_out_o(dio_out), .dio_oe_o(dio_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wr_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = wr_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_sec = '0; m_cyc = '0; m_ch = '0; m_armed = 1'b0; m_out = '0; m_oe = '0;
    endtask

    task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
        case (idx)
            3'd0: m_sec = merge(m_sec, d, s);
            3'd1: m_cyc = merge(m_cyc, d, s) & 32'h0FFF_FFFF;
            3'd2: begin
                if (s[0]) m_ch = d[2:0];
                if (s[1]) begin
                    if (d[9])      m_armed = 1'b0;
                    else if (d[8]) m_armed = 1'b1;
                end
            end
            3'd3: m_out = N'(merge(32'(m_out), d, s));
            3'd4: m_oe  = N'(merge(32'(m_oe), d, s));
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] idx);
        case (idx)
            3'd0: return m_sec;
            3'd1: return m_cyc;
            3'd2: return (32'(m_armed) << 8) | 32'(m_ch);
            3'd3: return 32'(m_out);
            3'd4: return 32'(m_oe);
            3'd5: return 32'(m_in);
            3'd6: return {30'b0, tm_valid, m_armed};
            default: return 32'h0;
        endcase
    endfunction

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
        @(negedge clk);
        check("wr_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        model_write(a[4:2], d, s);
    endtask

    task automatic wb_read(input logic [31:0] a, input string tag);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(negedge clk);
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check(tag, dat_o, exp_read(a[4:2]));
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic check_pads(input string tag);
        @(negedge clk);
        check({tag, "_out"}, 32'(dio_out), 32'(m_out));
        check({tag, "_oe"}, 32'(dio_oe), 32'(m_oe));
    endtask

    task automatic set_inputs(input logic [N-1:0] v);
        @(negedge clk);
        dio_in = v;
        repeat (3) @(negedge clk);
        m_in = v;
    endtask

    // Walk tm_cycles through the programmed trigger; a match (if any) happens at step 3.
    task automatic sweep(input logic valid, input string tag);
        int m;
        logic fire;
        logic [2:0] pch;
        logic [N-1:0] e;
        m = -100; fire = 1'b0; pch = m_ch;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            tm_valid = valid; tm_sec = m_sec; tm_cyc = 28'(m_cyc - 32'd3 + 32'(k));
            if (m_armed && valid && k == 3) begin
                m = k; fire = (32'(m_ch) < N); m_armed = 1'b0;
            end
            @(negedge clk);
            e = m_out;
            if (fire && k >= m && k < m + int'(L)) e[pch] = 1'b1;
            check(tag, 32'(dio_out), 32'(e));
        end
        tm_valid = 1'b0; tm_sec = ~m_sec;
    endtask

    initial begin
        logic [2:0] idx;
        logic [31:0] a, d;
        logic [3:0] s;
        model_reset();
        m_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_oe", 32'(dio_oe), 32'd0);
        check("rst_out", 32'(dio_out), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("stall", 32'(stall), 32'd0);
        rst = 1'b0;
        wb_read(32'h00, "rst_sec");

        // Pipelined back-to-back writes
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h00; dat_i = 32'hDEADBEEF;
        @(negedge clk);
        check("b2b_ack0", 32'(ack), 32'd1);
        adr = 32'h04; dat_i = 32'hCAFEBABE;
        @(negedge clk);
        check("b2b_ack1", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(ack), 32'd0);
        model_write(3'd0, 32'hDEADBEEF, 4'hF);
        model_write(3'd1, 32'hCAFEBABE, 4'hF);
        wb_read(32'h00, "sec");
        wb_read(32'h04, "cyc");
        check("cyc_const", exp_read(3'd1), 32'h0AFEBABE);

        // Pads and input synchronizer
        wb_write(32'h10, 32'h1F, 4'hF);
        wb_write(32'h0C, 32'h15, 4'hF);
        check_pads("pads");
        check("pads_const", 32'(dio_out), 32'h15);
        set_inputs(5'h0A);
        wb_read(32'h14, "in");

        // Trigger on CH2 at 100/50
        wb_write(32'h0C, 32'h11, 4'hF);
        wb_write(32'h00, 32'd100, 4'hF);
        wb_write(32'h04, 32'd50, 4'hF);
        wb_write(32'h08, 32'h102, 4'hF);
        sweep(1'b1, "trig_ch2");
        wb_read(32'h18, "stat_after");

        // Time invalid: no match, stays armed
        wb_write(32'h08, 32'h102, 4'hF);
        sweep(1'b0, "trig_invalid");
        wb_read(32'h18, "stat_invalid");

        // Partial write
        wb_write(32'h00, 32'hDEADBEEF, 4'hF);
        wb_write(32'h00, 32'h000000AA, 4'b0001);
        wb_read(32'h00, "partial");

        // ARM with DISARM
        wb_write(32'h08, 32'h100, 4'hF);
        wb_write(32'h08, 32'h300, 4'hF);
        wb_read(32'h08, "arm_disarm");

        // Out-of-range channel
        wb_write(32'h00, 32'd7, 4'hF);
        wb_write(32'h04, 32'd1000, 4'hF);
        wb_write(32'h08, 32'h107, 4'hF);
        sweep(1'b1, "trig_ch7");
        wb_read(32'h18, "stat_ch7");

        // Random register traffic
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) set_inputs(N'($urandom));
            idx = 3'($urandom_range(0, 7));
            a = ($urandom & ~32'h1C) | (32'(idx) << 2);
            d = $urandom;
            s = 4'($urandom);
            wb_write(a, d, s);
            if (idx == 3'd3 || idx == 3'd4) check_pads("rnd_pads");
            wb_read(a, "rnd_rd");
        end

        // Random triggers
        for (int i = 0; i < 6; i++) begin
            wb_write(32'h00, $urandom, 4'hF);
            wb_write(32'h04, 32'($urandom_range(3, 1000000)), 4'hF);
            wb_write(32'h0C, 32'($urandom), 4'hF);
            wb_write(32'h08, 32'h100 | 32'($urandom_range(0, 7)), 4'hF);
            sweep(1'($urandom_range(0, 3) != 0), "rnd_trig");
            wb_read(32'h18, "rnd_stat");
        end

        // Reset mid-pulse
        wb_write(32'h0C, 32'h0, 4'hF);
        wb_write(32'h08, 32'h100, 4'hF);
        @(negedge clk);
        tm_valid = 1'b1; tm_sec = m_sec; tm_cyc = 28'(m_cyc);
        @(negedge clk);
        tm_valid = 1'b0;
        check("pulse_on", 32'(dio_out), 32'h1);
        @(negedge clk);
        check("pulse_on2", 32'(dio_out), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pulse_out", 32'(dio_out), 32'h0);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pulse_gone", 32'(dio_out), 32'h0);
        wb_read(32'h18, "stat_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
